// File: rtl/mips_pkg.sv
// Shared Mips32 datapath constants, the fetch-queue entry type and PC helpers.
`default_nettype none

package mips_pkg;

  localparam int XLEN        = 32;
  localparam int INSTR_BYTES = 4;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
    return pc + XLEN'(INSTR_BYTES);
  endfunction

  function automatic logic [XLEN-1:0] align_pc(input logic [XLEN-1:0] pc);
    return pc & ~XLEN'(INSTR_BYTES - 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/pf_fifo.sv
// Synchronous in-order FIFO with synchronous flush; head is read straight from storage registers.
`default_nettype none

module pf_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             empty
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             do_push, do_pop, full;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head  = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

`default_nettype wire

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction prefetcher: credit-limited memory reads, in-order {pc, instr} queue,
// redirect flush with discard of in-flight responses.
`default_nettype none

module instr_prefetch_queue
  import mips_pkg::*;
#(
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [XLEN-1:0] imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_pc_plus4
);

  localparam int CW = $clog2(DEPTH + 1);

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   discard_q, discard_d;

  logic [CW-1:0]   q_count;
  logic            q_empty;
  fetch_entry_t    q_head;
  fetch_entry_t    push_entry;
  logic            credit_ok, req_fire, rsp_keep;

  // Occupancy plus outstanding reads never exceeds DEPTH, so every response has a slot.
  assign credit_ok      = ({1'b0, q_count} + {1'b0, inflight_q}) < (CW+1)'(DEPTH);
  assign imem_req_valid = rst_n && !redirect_valid && credit_ok;
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && !redirect_valid && (discard_q == '0);

  assign push_entry.pc    = rsp_pc_q;
  assign push_entry.instr = imem_rsp_data;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    discard_d  = discard_q;
    inflight_d = inflight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      fetch_pc_d = align_pc(redirect_pc);
      rsp_pc_d   = align_pc(redirect_pc);
      discard_d  = inflight_d;
    end else begin
      if (req_fire) begin
        fetch_pc_d = next_pc(fetch_pc_q);
      end
      if (imem_rsp_valid) begin
        if (discard_q != '0) begin
          discard_d = discard_q - CW'(1);
        end else begin
          rsp_pc_d = next_pc(rsp_pc_q);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      discard_q  <= discard_d;
    end
  end

  pf_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_valid),
    .push      (rsp_keep),
    .push_data (push_entry),
    .pop       (out_ready),
    .head      (q_head),
    .count     (q_count),
    .empty     (q_empty)
  );

  assign out_valid    = !q_empty;
  assign out_instr    = q_head.instr;
  assign out_pc       = q_head.pc;
  assign out_pc_plus4 = next_pc(q_head.pc);

endmodule

`default_nettype wire

// File: tb/tb_instr_prefetch_queue.sv
// Scoreboard bench: directed scenarios push expected PCs; a monitor checks every consumed instruction.
`default_nettype none

module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = 32'h0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_instr      (out_instr),
    .out_pc         (out_pc),
    .out_pc_plus4   (out_pc_plus4)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A00_00A5;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  // Instruction memory: fixed latency, in-order, optional ready stalls.
  typedef struct {
    logic [31:0] addr;
    int          due;
  } mreq_t;
  mreq_t mq[$];
  int    lat = 1;
  bit    stall_en = 1'b0;
  int    n_acc = 0;

  always @(negedge clk) begin
    imem_req_ready = stall_en ? ((cyc % 2) == 0) : 1'b1;
    if (!rst_n) begin
      mq.delete();
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end else if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
    end
    #1;
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mq.push_back('{addr: imem_addr, due: cyc + lat});
      n_acc++;
    end
  end

  // Monitor: every consumed head is compared against the next expected PC.
  logic [31:0] expq[$];

  always @(negedge clk) begin
    logic [31:0] epc;
    #2;
    if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready && !redirect_valid) begin
      if (expq.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_pop: got pc %h, required no output", out_pc);
      end else begin
        epc = expq.pop_front();
        check("out_pc", out_pc, epc);
        check("out_instr", out_instr, mem_word(epc));
        check("out_pc_plus4", out_pc_plus4, epc + 32'd4);
      end
    end
  end

  task automatic expect_run(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) expq.push_back(base + 32'(4 * i));
  endtask

  task automatic drain(input int budget);
    int k;
    for (k = 0; k < budget; k++) begin
      @(negedge clk);
      if (expq.size() == 0) break;
      out_ready = 1'b1;
    end
    out_ready = 1'b0;
    check("drain_left", 32'(expq.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_req_valid"}, 32'(imem_req_valid), 32'd0);
    check({tag, "_out_pc"}, out_pc, 32'h0);
    check({tag, "_out_instr"}, out_instr, 32'h0);
    check({tag, "_out_pc_plus4"}, out_pc_plus4, 32'h4);
  endtask

  initial begin
    int start;
    int n0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1 check_reset_outputs("reset");

    // Stalled consumer after reset: credit caps requests at DEPTH, then steady drain.
    lat = 1;
    @(negedge clk);
    rst_n = 1'b1;
    expect_run(32'h0, 8);
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr", imem_addr, 32'h0);
    @(negedge clk); #1 check("out_valid_c1", 32'(out_valid), 32'd0);
    @(negedge clk); #1 check("out_valid_c2", 32'(out_valid), 32'd1);
    repeat (8) @(negedge clk);
    check("credit_requests", 32'(n_acc), 32'd4);
    check("credit_req_valid", 32'(imem_req_valid), 32'd0);
    out_ready = 1'b1;
    start = cyc;
    @(negedge clk); #1;
    check("resume_req_valid", 32'(imem_req_valid), 32'd1);
    check("resume_addr", imem_addr, 32'h10);
    drain(100);
    check("drain_cycles", 32'(cyc - start), 32'd8);

    // 3-cycle memory, redirect with two reads outstanding.
    rst_n = 1'b0;
    lat = 3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    n0 = n_acc;
    @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    expect_run(32'h100, 8);
    #1;
    check("redir_req_blocked", 32'(imem_req_valid), 32'd0);
    check("redir_inflight", 32'(n_acc - n0), 32'd2);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("redir_out_valid", 32'(out_valid), 32'd0);
    check("redir_target_addr", imem_addr, 32'h100);
    drain(100);

    // Redirect coincident with a response and a ready consumer; misaligned target; PC wrap.
    repeat (6) @(negedge clk);
    lat = 1;
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    out_ready      = 1'b1;
    expq.push_back(32'h200);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("align_req_valid", 32'(imem_req_valid), 32'd1);
    check("align_addr", imem_addr, 32'h200);
    repeat (3) @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFF;
    expect_run(32'hFFFF_FFFC, 5);
    #1;
    check("coinc_out_valid", 32'(out_valid), 32'd1);
    check("coinc_head_pc", out_pc, 32'h204);
    check("coinc_rsp_valid", 32'(imem_rsp_valid), 32'd1);
    @(negedge clk);
    redirect_valid = 1'b0;
    #1;
    check("coinc_next_out_valid", 32'(out_valid), 32'd0);
    check("coinc_target_addr", imem_addr, 32'hFFFF_FFFC);
    @(negedge clk); #1;
    check("wrap_req_valid", 32'(imem_req_valid), 32'd1);
    check("wrap_addr", imem_addr, 32'h0);
    drain(100);

    // Reset asserted with three entries queued.
    repeat (6) @(negedge clk);
    @(negedge clk);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0400;
    @(negedge clk);
    redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    check("pre_reset_out_valid", 32'(out_valid), 32'd1);
    check("pre_reset_head_pc", out_pc, 32'h400);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    stall_en = 1'b1;
    rst_n    = 1'b1;
    expect_run(32'h0, 8);
    #1;
    check("restart_req_valid", 32'(imem_req_valid), 32'd1);
    check("restart_addr", imem_addr, 32'h0);
    drain(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: got no end of test, required completion before 200000");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/instr_prefetch_queue.md
# instr_prefetch_queue

Instruction fetch front end for the Mips32 datapath: it issues sequential word reads to instruction memory, buffers returned instructions with their PCs in a small in-order queue, and presents them to the decode/register-read stage with a valid/ready handshake. A branch/jump redirect from the execute stage flushes the queue, discards responses still in flight, and restarts fetch at the target. It replaces the free-running PC register plus `+4` adder at the top of the datapath.

## Interface
- DEPTH, 4, queue entries; power of two, 2..16
- RESET_PC, 32'h0000_0000, first fetch address after reset; word aligned
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- imem_req_valid  out  1  read request valid
- imem_req_ready  in  1  memory accepts request this cycle
- imem_addr  out  32  word-aligned fetch address
- imem_rsp_valid  in  1  read data valid; responses return in request order, ≥1 cycle after acceptance
- imem_rsp_data  in  32  instruction word
- redirect_valid  in  1  taken branch/jump; one-cycle pulse
- redirect_pc  in  32  new fetch address; bits [1:0] ignored (forced 0)
- out_valid  out  1  instruction available to decode
- out_ready  in  1  decode consumes head this cycle
- out_instr  out  32  instruction at queue head
- out_pc  out  32  address of out_instr
- out_pc_plus4  out  32  out_pc + 4 (feeds branch adder)

## Operation
- State: fetch_pc (32), queue of DEPTH {pc, instr}, inflight count, discard count (each 0..DEPTH).
- Credit rule: imem_req_valid = !redirect_valid && (occupancy + inflight < DEPTH) && out of reset. Guarantees every response has a free slot; queue never overflows.
- Request accepted when imem_req_valid && imem_req_ready: fetch_pc += 4 (mod 2^32, wraps 0xFFFF_FFFC → 0), inflight += 1. The PC of each in-flight request is tracked in order (small PC FIFO or computed from queue tail PC + 4).
- Response: inflight −= 1. If discard > 0, discard −= 1 and data dropped; otherwise {pc, instr} pushed at tail.
- Pop when out_valid && out_ready; push and pop same cycle allowed at any occupancy, including full.
- Redirect (priority over everything): queue emptied, fetch_pc ← {redirect_pc[31:2], 2'b00}, discard ← inflight after this cycle's response is accounted (a response arriving in the redirect cycle is itself dropped). out_ready ignored that cycle.
- Reset (any time, including mid-burst): fetch_pc = RESET_PC, queue empty, inflight = discard = 0, out_valid = 0, imem_req_valid = 0, out_instr/out_pc = 0, out_pc_plus4 = 4. Memory side must also be reset; no stale responses expected after reset.

## Timing
- out_* driven directly from queue head registers; no combinational path from imem_rsp_* or out_ready to out_*.
- imem_req_valid combinational only from redirect_valid and internal registers; no path from imem_req_ready.
- Redirect at cycle T: out_valid = 0 at T+1; request for target may issue at T+1; earliest out_valid for target at T+3 with 1-cycle memory.
- Steady state, 1-cycle memory, out_ready held 1: one instruction per cycle; first out_valid 2 cycles after reset release.
- Throughput limited only by DEPTH ≥ memory latency + 1.

## Structure
- Shared package `mips_pkg`: XLEN = 32, INSTR_BYTES = 4, RESET_PC default, nop encoding 32'h0000_0000.
- One sub-module: `pf_fifo`, parameterised synchronous FIFO (WIDTH, DEPTH, async active-low reset, synchronous flush, count output), used for the {pc, instr} queue.

## Test plan
- Reset release, 1-cycle memory, out_ready = 1: addresses 0,4,8,… issued each cycle; out_pc 0,4,8 with matching out_instr from cycle 2 on; out_pc_plus4 = out_pc + 4.
- out_ready = 0 for 10 cycles: exactly DEPTH (4) requests issued, then imem_req_valid = 0; release → 4 entries drain in order, fetch resumes at 0x10.
- 3-cycle memory latency, redirect to 0x100 with 2 in flight: both late responses dropped; next out_pc = 0x100; no queue overflow.
- Redirect coincident with imem_rsp_valid and out_ready = 1: response dropped, no pop observed, out_valid = 0 next cycle, imem_addr = target.
- redirect_pc = 0x203 → fetch at 0x200; fetch_pc 0xFFFF_FFFC → next request addr 0x0.
- rst_n asserted mid-stream with 3 entries queued: all outputs at reset values immediately; after release fetch restarts at RESET_PC.
